// File: rtl/fsm_sar_bs_pkg.sv
// Shared types and constants for the SAR binary-search ADC controller.
package fsm_sar_bs_pkg;

    localparam int unsigned N_BITS = 8;
    localparam logic [7:0] UIO_OE_MASK = 8'h07;

    localparam int unsigned START_BIT  = 0;
    localparam int unsigned CMP_BIT    = 1;
    localparam int unsigned SAMPLE_BIT = 0;
    localparam int unsigned BUSY_BIT   = 1;
    localparam int unsigned EOC_BIT    = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StConvert,
        StDone
    } sar_state_e;

endpackage

// File: rtl/fsm_sar_bs_if.sv
// Control/status bundle between the pin wrapper and the SAR core.
interface fsm_sar_bs_if;
    import fsm_sar_bs_pkg::*;

    logic              start;
    logic              cmp;
    logic [N_BITS-1:0] code;
    logic              sample;
    logic              busy;
    logic              eoc;

    modport ctrl (output start, cmp, input code, sample, busy, eoc);
    modport core (input start, cmp, output code, sample, busy, eoc);
endinterface

// File: rtl/fsm_sar_bs_sar_core.sv
// SAR conversion FSM: one sample cycle, eight binary-search decisions, one done cycle.
module fsm_sar_bs_sar_core
    import fsm_sar_bs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    fsm_sar_bs_if.core  bus
);

    sar_state_e        state_q, state_d;
    logic [N_BITS-1:0] code_q, code_d;
    logic [2:0]        idx_q, idx_d;

    // rst_n is an active-high synchronous reset despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= StIdle;
            code_q  <= '0;
            idx_q   <= 3'd7;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StSample;
            end
            StSample: begin
                state_d = StConvert;
                code_d  = 8'h80;
                idx_d   = 3'd7;
            end
            StConvert: begin
                // Resolve the current trial bit, then arm the next lower one.
                code_d[idx_q] = bus.cmp;
                if (idx_q != 3'd0) begin
                    code_d[idx_q - 3'd1] = 1'b1;
                    idx_d                = idx_q - 3'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.code   = code_q;
    assign bus.sample = (state_q == StSample);
    assign bus.busy   = (state_q == StSample) || (state_q == StConvert);
    assign bus.eoc    = (state_q == StDone);

endmodule

// File: rtl/fsm_sar_bs_top.sv
// Tiny Tapeout wrapper: maps the SAR core onto the fixed user-project pinout.
module fsm_sar_bs_top
    import fsm_sar_bs_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    fsm_sar_bs_if core_bus ();

    assign core_bus.start = ui_in[START_BIT];
    assign core_bus.cmp   = ui_in[CMP_BIT];

    fsm_sar_bs_sar_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (core_bus)
    );

    always_comb begin
        uio_out             = 8'h00;
        uio_out[SAMPLE_BIT] = core_bus.sample;
        uio_out[BUSY_BIT]   = core_bus.busy;
        uio_out[EOC_BIT]    = core_bus.eoc;
    end

    assign uo_out = core_bus.code;
    assign uio_oe = UIO_OE_MASK;

    logic unused_pins;
    assign unused_pins = ^{ena, uio_in, ui_in[7:2]};

endmodule

// File: tb/tb_fsm_sar_bs_top.sv
// Scoreboard bench for fsm_sar_bs_top: driver queues expected results, monitor checks on eoc.
module tb_fsm_sar_bs_top;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [5:0] noise;

    fsm_sar_bs_if bus ();

    int         cyc;
    int         cmp_mode;  // 0: cmp=0, 1: cmp=1, 2: behavioural comparator
    logic [7:0] vin_r;
    int         errors;
    int         checks;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    fsm_sar_bs_top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    assign bus.cmp    = (cmp_mode == 0) ? 1'b0 : (cmp_mode == 1) ? 1'b1 : (vin_r >= uo_out);
    assign ui_in      = {noise, bus.cmp, bus.start};
    assign bus.code   = uo_out;
    assign bus.sample = uio_out[0];
    assign bus.busy   = uio_out[1];
    assign bus.eoc    = uio_out[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        noise  <= 6'($urandom);
        uio_in <= 8'($urandom);
        ena    <= 1'($urandom);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every eoc cycle must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.eoc === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_eoc", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", int'(uo_out), int'(e.res));
                    check("eoc_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uio_out[2:0] == 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 1, 0);
    endtask

    task automatic run_conv(input logic [7:0] vin, input int mode, input bit toggle,
                            input bit seq_chk);
        logic [7:0] res;
        logic [7:0] exp_trial;
        int         n_sample;
        int         n_busy;
        wait_idle();
        vin_r    = vin;
        cmp_mode = mode;
        res      = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : vin;
        bus.start = 1'b1;
        sb.push_back('{res: res, cyc: cyc + 1 + 9});
        n_sample = 0;
        n_busy   = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            bus.start = toggle ? ((j % 2 == 0) && (j < 8)) : 1'b0;
            n_sample += int'(uio_out[0]);
            n_busy   += int'(uio_out[1]);
            if (seq_chk && j >= 1 && j <= 8) begin
                exp_trial = (mode == 1) ? ~(8'hFF >> j) : (8'h80 >> (j - 1));
                check("trial_code", int'(uo_out), int'(exp_trial));
            end
        end
        if (seq_chk) begin
            check("sample_cycles", n_sample, 1);
            check("busy_cycles", n_busy, 9);
        end
        @(negedge clk);
        check("result_hold", int'(uo_out), int'(res));
    endtask

    task automatic run_b2b(input logic [7:0] vin);
        int k;
        wait_idle();
        vin_r     = vin;
        cmp_mode  = 2;
        bus.start = 1'b1;
        k = cyc + 1;
        sb.push_back('{res: vin, cyc: k + 9});
        sb.push_back('{res: vin, cyc: k + 20});
        for (int j = 0; j < 11; j++) @(negedge clk);
        check("b2b_idle_gap", int'(uio_out[2:0]), 0);
        @(negedge clk);
        check("b2b_resample", int'(uio_out[0]), 1);
        bus.start = 1'b0;
        for (int j = 0; j < 10; j++) @(negedge clk);
    endtask

    task automatic run_abort();
        wait_idle();
        vin_r     = 8'h33;
        cmp_mode  = 2;
        bus.start = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("abort_busy_before", int'(uio_out[1]), 1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check("abort_code", int'(uo_out), 0);
        check("abort_status", int'(uio_out), 0);
        run_conv(8'h5A, 2, 1'b0, 1'b0);
    endtask

    initial begin
        automatic logic [7:0] dir_vec[5] = '{8'hA5, 8'h00, 8'h7F, 8'h80, 8'hFF};
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        cmp_mode  = 1;
        vin_r     = 8'h00;
        bus.start = 1'b1;
        rst_n     = 1'b1;
        noise     = '0;
        uio_in    = '0;
        ena       = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_uo_out", int'(uo_out), 0);
            check("rst_uio_out", int'(uio_out), 0);
            check("rst_uio_oe", int'(uio_oe), 8'h07);
        end
        rst_n     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", int'(uio_out), 0);

        run_conv(8'h00, 1, 1'b0, 1'b1);
        run_conv(8'h00, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) run_conv(dir_vec[i], 2, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) run_conv(8'($urandom_range(0, 255)), 2, 1'b0, 1'b0);
        run_conv(8'h3C, 2, 1'b1, 1'b0);
        run_b2b(8'hC3);
        run_abort();

        for (int i = 0; i < 5; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fsm_sar_bs_top.md
Name: fsm_sar_bs_top

Overview:
- Tiny Tapeout user-project wrapper holding a successive-approximation (SAR) ADC controller that uses an 8-bit binary search.
- The off-chip comparator result enters on ui_in; the DAC trial code leaves on uo_out.
- Status strobes (sample, busy, end-of-conversion) are driven on the bidirectional pins.
- The block is the top of the user design and sits directly under the Tiny Tapeout harness.

Parameters:
- none at top level (fixed TT pinout)
- internal localparam N_BITS, 8, resolution of the conversion

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset; synchronous and active-high: 1 sampled at a clk edge resets the block, 0 means run (name kept per codebase convention)
- ena  input  1  harness enable; ignored
- ui_in  input  8  [0]=start, [1]=cmp (1 means Vin >= Vdac(code)), [7:2] unused
- uio_in  input  8  unused
- uo_out  output  8  DAC code: trial code during conversion, final result otherwise
- uio_out  output  8  [0]=sample, [1]=busy, [2]=eoc, [7:3]=0
- uio_oe  output  8  constant 8'b0000_0111

Behaviour:
- States: IDLE, SAMPLE, CONVERT, DONE.
- Registers: state, code[7:0], bit index idx[2:0].
- Reset (rst_n=1 at an edge): state=IDLE, code=0x00, idx=7. All outputs then read 0 (uo_out=0x00, sample=busy=eoc=0). Reset has priority in every state and aborts a conversion mid-flight.
- IDLE:
  - start=1 at an edge -> SAMPLE.
  - Otherwise stay in IDLE; code holds the previous result.
  - start is level-sensitive and sampled only in IDLE; it is ignored in all other states.
- SAMPLE: lasts exactly 1 cycle. At the next edge -> CONVERT, code=0x80, idx=7.
- CONVERT, at each edge with bit index i:
  - code[i] <= cmp.
  - If i>0: code[i-1] <= 1 and idx <= i-1.
  - If i==0: go to DONE.
  - Exactly 8 CONVERT cycles per conversion. cmp for bit i is sampled at the edge that ends the cycle in which code shows bit i set.
- DONE: lasts exactly 1 cycle, code frozen at the result. At the next edge -> IDLE, unconditionally. A held-high start therefore restarts one IDLE cycle later.
- Combinational outputs:
  - sample = (state==SAMPLE)
  - busy = (state==SAMPLE or CONVERT)
  - eoc = (state==DONE)
  - uo_out = code
- Latency: start seen at edge k -> sample high in cycle k..k+1; CONVERT cycles k+1..k+9; eoc high between edges k+9 and k+10; result valid on uo_out from edge k+9 until the next SAMPLE->CONVERT transition.
- Comparator glitches: cmp is used only at decision edges; values in other cycles have no effect.
- No X propagation: unused inputs never affect outputs.

Decomposition:
- Shared package fsm_sar_bs_pkg: state enum (IDLE, SAMPLE, CONVERT, DONE), N_BITS=8, UIO_OE_MASK=8'h07, pin-index constants (START_BIT=0, CMP_BIT=1, SAMPLE_BIT=0, BUSY_BIT=1, EOC_BIT=2).
- One natural sub-module, sar_core: clk, rst_n, start, cmp in; code[7:0], sample, busy, eoc out.
- The top level only does pin mapping and ties off unused inputs.

Test Plan:
- Reset: rst_n=1 for 2 cycles, with start=1 during reset -> uo_out=0x00, uio_out=0x00, uio_oe=0x07; state stays IDLE through reset.
- cmp held 1, pulse start for 1 cycle:
  - sample high for exactly 1 cycle, busy high for 9 cycles.
  - uo_out sequence 0x80,0xC0,0xE0,...,0xFF.
  - eoc high for 1 cycle with uo_out=0xFF.
- cmp held 0: trial codes 0x80,0x40,0x20,...,0x01; final result 0x00 with eoc pulse.
- Behavioural comparator cmp=(Vin>=uo_out):
  - Vin=0xA5 -> result 0xA5.
  - Also check Vin=0x00, 0x7F, 0x80, 0xFF, and 20 random values -> result equals Vin each time, eoc 10 cycles after start was sampled.
- start toggled during CONVERT -> no effect on code or timing. start held high -> back-to-back conversions, one IDLE cycle between the eoc cycle and the next sample.
- Assert rst_n at CONVERT idx=3 -> next cycle IDLE, uo_out=0x00, busy=0. A new start afterwards converts Vin=0x5A correctly.
